mul: RTL and testbench

Sequential 16-bit unsigned multiplier using repeated addition. Operands arrive one after another on a shared 16-bit input bus after a `start` request. The block then accumulates A into the product B times and raises `done` when finished. It is a small arithmetic coprocessor that a controller drives over a start/done handshake.

---
 rtl/mul_pkg.sv | 21 ++
 rtl/mul_ctrl.sv | 52 +++++
 rtl/mul.sv | 69 ++++++
 tb/tb_mul.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the repeated-addition multiplier: default width and
// controller state encoding.
package mul_pkg;

    localparam int MUL_WIDTH = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_A = 3'd1;
    localparam logic [2:0] ST_LOAD_B = 3'd2;
    localparam logic [2:0] ST_CALC   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        LOAD_A = ST_LOAD_A,
        LOAD_B = ST_LOAD_B,
        CALC   = ST_CALC,
        DONE   = ST_DONE
    } mul_state_t;

endpackage

// File: rtl/mul_ctrl.sv
// Controller for the multiplier: sequences operand loads, the accumulate loop
// and the start/done handshake.
module mul_ctrl
    import mul_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_eqz,
    output logic o_ld_a,
    output logic o_ld_b,
    output logic o_clr_p,
    output logic o_ld_p,
    output logic o_dec_b,
    output logic o_done
);

    mul_state_t r_state;
    mul_state_t w_state_nxt;
    logic       r_done;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_nxt = LOAD_A;
            LOAD_A:  w_state_nxt = LOAD_B;
            LOAD_B:  w_state_nxt = i_eqz ? DONE : CALC;
            CALC:    if (i_eqz) w_state_nxt = DONE;
            // A held-high start must not retrigger; only a low start releases DONE.
            DONE:    if (!i_start) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (w_state_nxt == DONE);
        end
    end

    assign o_ld_a  = (r_state == LOAD_A);
    assign o_ld_b  = (r_state == LOAD_B);
    assign o_clr_p = (r_state == LOAD_B);
    assign o_ld_p  = (r_state == CALC);
    assign o_dec_b = (r_state == CALC);
    assign o_done  = r_done;

endmodule

// File: rtl/mul.sv
// Sequential unsigned multiplier: adds A into P once per cycle while B counts
// down to zero. Product wraps modulo 2^WIDTH.
module mul
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_p;

    logic             w_ld_a;
    logic             w_ld_b;
    logic             w_clr_p;
    logic             w_ld_p;
    logic             w_dec_b;
    logic             w_eqz;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_b_dec;
    logic [WIDTH-1:0] w_b_nxt;

    assign w_sum   = r_p + r_a;
    assign w_b_dec = r_b - {{(WIDTH-1){1'b0}}, 1'b1};

    // Zero test on the value B takes at this edge, so the controller leaves
    // LOAD_B/CALC on the same edge that B reaches zero.
    assign w_b_nxt = w_ld_b ? data_in : w_b_dec;
    assign w_eqz   = (w_b_nxt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a <= '0;
            r_b <= '0;
            r_p <= '0;
        end else begin
            if (w_ld_a) r_a <= data_in;

            if (w_ld_b)       r_b <= data_in;
            else if (w_dec_b) r_b <= w_b_dec;

            if (w_clr_p)     r_p <= '0;
            else if (w_ld_p) r_p <= w_sum;
        end
    end

    mul_ctrl u_ctrl (
        .clk     (clk),
        .rst     (rst),
        .i_start (start),
        .i_eqz   (w_eqz),
        .o_ld_a  (w_ld_a),
        .o_ld_b  (w_ld_b),
        .o_clr_p (w_clr_p),
        .o_ld_p  (w_ld_p),
        .o_dec_b (w_dec_b),
        .o_done  (done)
    );

    assign product = r_p;

endmodule

// File: tb/tb_mul.sv
// Bench for mul: fixed operand table, random operands against an arithmetic
// model, and hand sequences for reset abort and held start.
module tb_mul;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] data_in;
    logic        done;
    logic [15:0] product;

    int checks;
    int failures;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] p;
        int          lat;
    } vec_t;

    vec_t vecs[7];

    mul #(.WIDTH(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .data_in (data_in),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Leaves the DUT after the B-capture edge with an ignored value on the bus.
    task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic hold);
        @(posedge clk);
        @(negedge clk);
        start   = 1'b1;
        data_in = 16'h0;
        @(posedge clk);
        @(negedge clk);
        start   = hold;
        data_in = a;
        @(posedge clk);
        @(negedge clk);
        data_in = b;
        @(posedge clk);
        @(negedge clk);
        data_in = 16'd5;
    endtask

    task automatic wait_done(input int b, output int lat);
        int cycles;
        cycles = 2;
        while (!done && cycles < b + 20) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        if (!done) begin
            failures++;
            checks++;
            $display("FAIL done_timeout actual=%0d required=%0d", cycles, b + 2);
        end
        lat = cycles;
    endtask

    task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_p, input int exp_lat);
        int lat;
        launch(a, b, 1'b0);
        wait_done(int'(b), lat);
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_product"}, product, exp_p);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic [31:0] full;
        int          lat;

        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        data_in  = 16'h0;

        vecs[0] = '{a: 16'd15,    b: 16'd15,  p: 16'd225,   lat: 17};
        vecs[1] = '{a: 16'd7,     b: 16'd0,   p: 16'd0,     lat: 2};
        vecs[2] = '{a: 16'd0,     b: 16'd9,   p: 16'd0,     lat: 11};
        vecs[3] = '{a: 16'd300,   b: 16'd300, p: 16'd24464, lat: 302};
        vecs[4] = '{a: 16'd65535, b: 16'd2,   p: 16'd65534, lat: 4};
        vecs[5] = '{a: 16'd1,     b: 16'd1,   p: 16'd1,     lat: 3};
        vecs[6] = '{a: 16'd3,     b: 16'd4,   p: 16'd12,    lat: 6};

        repeat (2) @(negedge clk);
        chk("reset_done", done, 0);
        chk("reset_product", product, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_done", done, 0);

        for (int i = 0; i < 7; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].lat);
        end

        // Reset in the middle of 15x15: P is live and partial before the abort.
        launch(16'd15, 16'd15, 1'b0);
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("calc_partial_product", product, 75);
        chk("calc_done_low", done, 0);
        #1 rst = 1'b1;
        #1;
        chk("abort_done", done, 0);
        chk("abort_product", product, 0);
        @(negedge clk);
        rst = 1'b0;
        run_op("after_abort", 16'd3, 16'd4, 16'd12, 6);

        // Held start: stays in DONE with a stable product until start drops.
        launch(16'd4, 16'd5, 1'b1);
        wait_done(5, lat);
        chk("held_latency", lat, 7);
        chk("held_product", product, 20);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("held_done_%0d", i), done, 1);
            chk($sformatf("held_stable_%0d", i), product, 20);
        end
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("release_done", done, 0);
        run_op("restart", 16'd3, 16'd4, 16'd12, 6);

        for (int i = 0; i < 20; i++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom_range(0, 40));
            full = 32'(ra) * 32'(rb);
            run_op($sformatf("rand%0d", i), ra, rb, full[15:0], int'(rb) + 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
